// File: rtl/neuron_mac_if.sv
// Beat-stream and result handshake bundle for the neuron MAC front end.
// The master drives beats and out_ready. The slave (the accumulator) returns the result.
interface neuron_mac_if #(
  parameter int data_width = 16,
  parameter int cnt_width  = 11
);
  logic signed [data_width-1:0]   in_x;
  logic signed [data_width-1:0]   in_w;
  logic signed [data_width-1:0]   in_bias;
  logic                           in_last;
  logic                           in_valid;
  logic                           in_ready;
  logic signed [2*data_width-1:0] out_sum;
  logic                           out_valid;
  logic                           out_ready;
  logic                           out_sat;
  logic                           out_overrun;
  logic [cnt_width-1:0]           beat_count;

  modport master (
    output in_x, in_w, in_bias, in_last, in_valid, out_ready,
    input  in_ready, out_sum, out_valid, out_sat, out_overrun, beat_count
  );

  modport slave (
    input  in_x, in_w, in_bias, in_last, in_valid, out_ready,
    output in_ready, out_sum, out_valid, out_sat, out_overrun, beat_count
  );
endinterface

// File: rtl/neuron_mac_accumulator.sv
// Sequential signed MAC with bias, saturating 2*data_width accumulator and overrun guard.
// state | meaning
// IDLE  | waiting for the first beat; the bias is taken from this beat
// ACCUM | adding further products; idle gaps hold the partial sum
// DONE  | result presented; beats stalled until the result is consumed
module neuron_mac_accumulator #(
  parameter int data_width = 16,
  parameter int frac_bits  = 12,
  parameter int max_inputs = 1024
) (
  input logic        clk,
  input logic        rst,
  neuron_mac_if.slave bus
);
  localparam int acc_width = 2 * data_width;
  localparam int cnt_width = $clog2(max_inputs) + 1;
  localparam logic [cnt_width-1:0] cnt_max = cnt_width'(max_inputs);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                       state_q, state_d;
  logic signed [acc_width-1:0]  acc_q, acc_d;
  logic [cnt_width-1:0]         cnt_q, cnt_d;
  logic                         in_ready_q, in_ready_d;
  logic                         out_valid_q, out_valid_d;
  logic                         sat_q, sat_d;
  logic                         ovr_q, ovr_d;

  logic signed [acc_width-1:0]  x_ext, w_ext, bias_ext;
  logic signed [acc_width-1:0]  prod, prod_sh, base;
  logic signed [acc_width:0]    sum_wide;
  logic signed [acc_width-1:0]  sum_clamp;
  logic                         clamp_hit;
  logic [cnt_width-1:0]         cnt_next;
  logic                         accept;

  assign x_ext    = {{data_width{bus.in_x[data_width-1]}}, bus.in_x};
  assign w_ext    = {{data_width{bus.in_w[data_width-1]}}, bus.in_w};
  assign bias_ext = {{data_width{bus.in_bias[data_width-1]}}, bus.in_bias};
  assign prod     = x_ext * w_ext;
  assign prod_sh  = prod >>> frac_bits;
  assign base     = (state_q == IDLE) ? bias_ext : acc_q;
  assign sum_wide = {base[acc_width-1], base} + {prod_sh[acc_width-1], prod_sh};
  assign cnt_next = (state_q == IDLE) ? cnt_width'(1) : cnt_q + cnt_width'(1);
  assign accept   = bus.in_valid & in_ready_q;

  // One guard bit is enough: the two top bits disagree exactly when the sum left the range.
  always_comb begin
    clamp_hit = sum_wide[acc_width] ^ sum_wide[acc_width-1];
    sum_clamp = sum_wide[acc_width-1:0];
    if (clamp_hit) begin
      if (sum_wide[acc_width]) sum_clamp = {1'b1, {(acc_width-1){1'b0}}};
      else                     sum_clamp = {1'b0, {(acc_width-1){1'b1}}};
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    sat_d       = sat_q;
    ovr_d       = ovr_q;
    case (state_q)
      IDLE, ACCUM: begin
        in_ready_d = 1'b1;
        if (accept) begin
          acc_d = sum_clamp;
          cnt_d = cnt_next;
          sat_d = (state_q == ACCUM) ? (sat_q | clamp_hit) : clamp_hit;
          if (bus.in_last || cnt_next == cnt_max) begin
            state_d     = DONE;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            ovr_d       = ~bus.in_last;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        // Ready rises only after the consume edge, giving the one-cycle bubble.
        if (bus.out_ready) begin
          state_d     = IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          sat_d       = 1'b0;
          ovr_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
      ovr_q       <= ovr_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_sum     = acc_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_sat     = sat_q;
  assign bus.out_overrun = ovr_q;
  assign bus.beat_count  = cnt_q;
endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Directed bench for neuron_mac_accumulator: three configurations share one stimulus stream,
// and a reference model pushes expected results that are popped when out_valid is seen.
module tb_neuron_mac_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic signed [15:0] tx, tw, tbias;
  logic tlast, tvalid, tout_ready;
  logic [1:0] sel;

  neuron_mac_if #(.data_width(16), .cnt_width(11)) ifa ();
  neuron_mac_if #(.data_width(16), .cnt_width(11)) ifb ();
  neuron_mac_if #(.data_width(16), .cnt_width(3))  ifc ();

  assign ifa.in_x = tx;  assign ifa.in_w = tw;  assign ifa.in_bias = tbias;
  assign ifa.in_last = tlast;  assign ifa.in_valid = tvalid;  assign ifa.out_ready = tout_ready;
  assign ifb.in_x = tx;  assign ifb.in_w = tw;  assign ifb.in_bias = tbias;
  assign ifb.in_last = tlast;  assign ifb.in_valid = tvalid;  assign ifb.out_ready = tout_ready;
  assign ifc.in_x = tx;  assign ifc.in_w = tw;  assign ifc.in_bias = tbias;
  assign ifc.in_last = tlast;  assign ifc.in_valid = tvalid;  assign ifc.out_ready = tout_ready;

  neuron_mac_accumulator #(.data_width(16), .frac_bits(12), .max_inputs(1024))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  neuron_mac_accumulator #(.data_width(16), .frac_bits(0), .max_inputs(1024))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  neuron_mac_accumulator #(.data_width(16), .frac_bits(12), .max_inputs(4))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));

  logic        obs_in_ready, obs_out_valid, obs_sat, obs_ovr;
  logic [31:0] obs_sum;
  logic [15:0] obs_cnt;
  assign obs_in_ready  = (sel == 2'd0) ? ifa.in_ready    : (sel == 2'd1) ? ifb.in_ready    : ifc.in_ready;
  assign obs_out_valid = (sel == 2'd0) ? ifa.out_valid   : (sel == 2'd1) ? ifb.out_valid   : ifc.out_valid;
  assign obs_sat       = (sel == 2'd0) ? ifa.out_sat     : (sel == 2'd1) ? ifb.out_sat     : ifc.out_sat;
  assign obs_ovr       = (sel == 2'd0) ? ifa.out_overrun : (sel == 2'd1) ? ifb.out_overrun : ifc.out_overrun;
  assign obs_sum       = (sel == 2'd0) ? ifa.out_sum     : (sel == 2'd1) ? ifb.out_sum     : ifc.out_sum;
  assign obs_cnt       = (sel == 2'd0) ? 16'(ifa.beat_count) :
                         (sel == 2'd1) ? 16'(ifb.beat_count) : 16'(ifc.beat_count);

  typedef struct {
    logic [31:0] sum;
    logic        sat;
    logic        ovr;
    int          cnt;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  localparam longint sat_hi = 64'sd2147483647;
  localparam longint sat_lo = -64'sd2147483648;
  longint m_acc;
  bit     m_first;
  bit     m_sat;
  int     m_cnt;
  int     cur_fb;
  int     cur_max;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint pshift(input shortint x, input shortint w, input int fb);
    longint p;
    p = longint'(x) * longint'(w);
    return p >>> fb;
  endfunction

  task automatic model_step(input shortint x, input shortint w, input shortint b, input bit last);
    exp_t e;
    if (m_first) begin
      m_acc = longint'(b);
      m_cnt = 0;
      m_sat = 1'b0;
      m_first = 1'b0;
    end
    m_acc = m_acc + pshift(x, w, cur_fb);
    m_cnt++;
    if (m_acc > sat_hi) begin
      m_acc = sat_hi;
      m_sat = 1'b1;
    end else if (m_acc < sat_lo) begin
      m_acc = sat_lo;
      m_sat = 1'b1;
    end
    if (last || m_cnt == cur_max) begin
      e.sum = m_acc[31:0];
      e.sat = m_sat;
      e.ovr = !last;
      e.cnt = m_cnt;
      sb.push_back(e);
      m_first = 1'b1;
    end
  endtask

  task automatic send_beat(input shortint x, input shortint w, input shortint b, input bit last);
    bit accepted;
    accepted = 1'b0;
    tx = x; tw = w; tbias = b; tlast = last; tvalid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (obs_in_ready) begin
        @(posedge clk); #1;
        accepted = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
    n_cmp++;
    assert (accepted) else begin
      n_err++;
      $error("FAIL beat_accept observed=0 expected=1");
    end
    if (accepted) model_step(x, w, b, last);
  endtask

  task automatic wait_out(output int waited);
    waited = 0;
    while (!obs_out_valid && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    n_cmp++;
    assert (obs_out_valid === 1'b1) else begin
      n_err++;
      $error("FAIL out_valid_timeout observed=%b expected=1", obs_out_valid);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    n_cmp++;
    assert (sb.size() > 0) else begin
      n_err++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_sum"}, 64'(obs_sum), 64'(e.sum));
      chk({tag, "_sat"}, 64'(obs_sat), 64'(e.sat));
      chk({tag, "_ovr"}, 64'(obs_ovr), 64'(e.ovr));
      chk({tag, "_cnt"}, 64'(obs_cnt), 64'(e.cnt));
    end
  endtask

  task automatic consume(input string tag);
    tout_ready = 1'b1;
    @(posedge clk); #1;
    tout_ready = 1'b0;
    chk({tag, "_rdy_after"}, 64'(obs_in_ready), 64'd1);
    chk({tag, "_vld_after"}, 64'(obs_out_valid), 64'd0);
  endtask

  task automatic do_reset(input logic [1:0] s, input int fb, input int mx);
    sel = s; cur_fb = fb; cur_max = mx;
    tvalid = 1'b0; tout_ready = 1'b0; tlast = 1'b0;
    rst = 1'b1;
    sb.delete();
    m_first = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(obs_out_valid), 64'd0);
    chk("rst_out_sum", 64'(obs_sum), 64'd0);
    chk("rst_beat_count", 64'(obs_cnt), 64'd0);
    chk("rst_sat_ovr", {62'd0, obs_sat, obs_ovr}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(obs_in_ready), 64'd1);
  endtask

  initial begin
    int waited;
    logic [31:0] held;
    tx = '0; tw = '0; tbias = '0; tlast = 1'b0; tvalid = 1'b0; tout_ready = 1'b0;
    sel = 2'd0; m_acc = 0; m_sat = 1'b0; m_cnt = 0; m_first = 1'b1;

    // default configuration
    do_reset(2'd0, 12, 1024);
    send_beat(4096, 8192, 100, 1'b1);
    wait_out(waited);
    chk("single_latency", 64'(waited), 64'd0);
    chk("single_sum_const", 64'(obs_sum), 64'h2064);
    check_out("single");
    consume("single");

    send_beat(-4096, 4096, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    send_beat(0, 4096, 0, 1'b1);
    wait_out(waited);
    chk("neg_sum_const", 64'(obs_sum), 64'hFFFF_F000);
    check_out("neg");
    consume("neg");

    send_beat(1, 1, 5, 1'b0);
    send_beat(-1, 1, 0, 1'b1);
    wait_out(waited);
    check_out("floor");
    consume("floor");

    send_beat(4096, 4096, -7, 1'b1);
    wait_out(waited);
    held = obs_sum;
    check_out("bp");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_sum_stable", 64'(obs_sum), 64'(held));
      chk("bp_in_ready", 64'(obs_in_ready), 64'd0);
      chk("bp_out_valid", 64'(obs_out_valid), 64'd1);
    end
    consume("bp");
    send_beat(4096, 4096, 10, 1'b0);
    send_beat(4096, 8192, 999, 1'b1);
    wait_out(waited);
    check_out("fresh_bias");
    consume("fresh_bias");

    send_beat(4096, 4096, 0, 1'b0);
    send_beat(4096, 4096, 0, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_cnt", 64'(obs_cnt), 64'd0);
    chk("async_rst_sum", 64'(obs_sum), 64'd0);
    do_reset(2'd0, 12, 1024);
    send_beat(4096, 4096, 0, 1'b1);
    wait_out(waited);
    chk("after_rst_sum_const", 64'(obs_sum), 64'h1000);
    check_out("after_rst");
    consume("after_rst");

    // frac_bits = 0: saturation in both directions and accumulation from a clamped value
    do_reset(2'd1, 0, 1024);
    for (int i = 0; i < 3; i++) send_beat(-32768, -32768, 0, i == 2);
    wait_out(waited);
    chk("sat_pos_const", 64'(obs_sum), 64'h7FFF_FFFF);
    check_out("sat_pos");
    consume("sat_pos");
    for (int i = 0; i < 3; i++) send_beat(-32768, 32767, 0, i == 2);
    wait_out(waited);
    check_out("sat_neg");
    consume("sat_neg");
    send_beat(-32768, -32768, 0, 1'b0);
    send_beat(-32768, -32768, 0, 1'b0);
    send_beat(-32768, 32767, 0, 1'b1);
    wait_out(waited);
    chk("sat_resume_const", 64'(obs_sum), 64'h4000_7FFF);
    check_out("sat_resume");
    consume("sat_resume");
    send_beat(3, 5, 1, 1'b1);
    wait_out(waited);
    check_out("sat_cleared");
    consume("sat_cleared");

    // max_inputs = 4: overrun and exact-limit evaluations
    do_reset(2'd2, 12, 4);
    for (int i = 0; i < 4; i++) send_beat(4096, 4096, 1, 1'b0);
    wait_out(waited);
    check_out("ovr");
    tx = 16'sd4096; tw = 16'sd4096; tbias = 16'sd1; tlast = 1'b0; tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("ovr_stall_rdy", 64'(obs_in_ready), 64'd0);
      chk("ovr_hold_cnt", 64'(obs_cnt), 64'd4);
    end
    tvalid = 1'b0;
    consume("ovr");
    for (int i = 0; i < 4; i++) send_beat(4096, 4096, 2, i == 3);
    wait_out(waited);
    check_out("limit_last");
    consume("limit_last");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
